l1_mem_arbiter: RTL and testbench

- Sits directly below the pipelined I-cache and D-cache controllers. It serialises their cacheline requests onto one burst-oriented physical memory port.
- Converts each 256-bit line transfer into 4 beats of 64 bits and returns the assembled line with a one-cycle response pulse.
- The D-cache's miss fill (pmem_read) and write-back (pmem_write) paths terminate here, as does the I-cache miss path.

---
 rtl/cache_mux_types.sv | 25 ++
 rtl/cacheline_adaptor.sv | 94 +++++++++
 rtl/l1_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_l1_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mux_types.sv
// Shared types and constants for the L1 memory arbiter and its cacheline adaptor.
package cache_mux_types;

    localparam int LINE_OFFSET_BITS = 5;
    localparam int BURST_BEATS      = 4;

    typedef enum logic [2:0] {
        IDLE,
        I_READ,
        D_READ,
        D_WRITE,
        DONE
    } arb_state_t;

    typedef enum logic {
        GRANT_I,
        GRANT_D
    } arb_grant_t;

    // Clear the byte-within-line offset so bursts always start on a line boundary.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & ~((32'd1 << LINE_OFFSET_BITS) - 32'd1);
    endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Splits one cacheline transfer into BEATS memory beats and reassembles read beats.
module cacheline_adaptor
    import cache_mux_types::*;
#(
    parameter int BEAT_WIDTH = 64,
    parameter int BEATS      = BURST_BEATS,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    // line side
    input  logic                  start,
    input  logic                  line_read,
    input  logic                  line_write,
    input  logic [31:0]           line_address,
    input  logic [LINE_WIDTH-1:0] line_wdata,
    output logic [LINE_WIDTH-1:0] line_rdata,
    output logic                  line_done,
    // burst side
    output logic                  burst_read,
    output logic                  burst_write,
    output logic [31:0]           burst_address,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    input  logic [BEAT_WIDTH-1:0] burst_rdata,
    input  logic                  burst_resp
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    logic                  busy_q, busy_d;
    logic                  wr_q, wr_d;
    logic [CW-1:0]         k_q, k_d;
    logic [31:0]           addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wbuf_q, wbuf_d;
    logic [LINE_WIDTH-1:0] rbuf_q, rbuf_d;

    // Latch a new transfer on start, then step one beat per burst_resp.
    always_comb begin
        busy_d    = busy_q;
        wr_d      = wr_q;
        k_d       = k_q;
        addr_d    = addr_q;
        wbuf_d    = wbuf_q;
        rbuf_d    = rbuf_q;
        line_done = 1'b0;
        if (start && (line_read || line_write)) begin
            busy_d = 1'b1;
            wr_d   = line_write;
            k_d    = '0;
            addr_d = line_align(line_address);
            if (line_write) begin
                wbuf_d = line_wdata;
            end
        end else if (busy_q && burst_resp) begin
            if (!wr_q) begin
                rbuf_d[BEAT_WIDTH*int'(k_q) +: BEAT_WIDTH] = burst_rdata;
            end
            k_d = k_q + 1'b1;
            if (k_q == LAST_BEAT) begin
                busy_d    = 1'b0;
                line_done = 1'b1;
            end
        end
    end

    // Transfer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            wr_q   <= 1'b0;
            k_q    <= '0;
            addr_q <= '0;
            wbuf_q <= '0;
            rbuf_q <= '0;
        end else begin
            busy_q <= busy_d;
            wr_q   <= wr_d;
            k_q    <= k_d;
            addr_q <= addr_d;
            wbuf_q <= wbuf_d;
            rbuf_q <= rbuf_d;
        end
    end

    // The final beat lands in rbuf on the same edge the arbiter captures the line,
    // so expose the next-state value to include it.
    assign line_rdata    = rbuf_d;
    assign burst_read    = busy_q & ~wr_q;
    assign burst_write   = busy_q & wr_q;
    assign burst_address = addr_q;
    assign burst_wdata   = wbuf_q[BEAT_WIDTH*int'(k_q) +: BEAT_WIDTH];

endmodule

// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter serialising I-cache and D-cache line requests onto one burst port.
module l1_mem_arbiter
    import cache_mux_types::*;
#(
    parameter int BEAT_WIDTH = 64,
    parameter int BEATS      = BURST_BEATS,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pmem_read,
    input  logic [31:0]           i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [31:0]           d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  burst_read,
    output logic                  burst_write,
    output logic [31:0]           burst_address,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    input  logic [BEAT_WIDTH-1:0] burst_rdata,
    input  logic                  burst_resp
);

    arb_state_t            state_q, state_d;
    arb_grant_t            last_q, last_d;
    logic                  i_resp_q, i_resp_d;
    logic                  d_resp_q, d_resp_d;
    logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;

    logic                  i_req, d_req, d_pick;
    logic                  start, start_write;
    logic [31:0]           start_addr;
    logic [LINE_WIDTH-1:0] line_rdata;
    logic                  line_done;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // Arbitrate in IDLE, wait for the adaptor in a burst state, route the response.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        i_resp_d    = 1'b0;
        d_resp_d    = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        start       = 1'b0;
        start_write = 1'b0;
        start_addr  = i_pmem_address;
        // On a tie, the side that did not win last time goes first.
        d_pick      = d_req && (!i_req || (last_q == GRANT_I));
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    start = 1'b1;
                    if (d_pick) begin
                        start_addr  = d_pmem_address;
                        start_write = d_pmem_write;
                        last_d      = GRANT_D;
                        state_d     = d_pmem_write ? D_WRITE : D_READ;
                    end else begin
                        last_d  = GRANT_I;
                        state_d = I_READ;
                    end
                end
            end
            I_READ: begin
                if (line_done) begin
                    state_d   = DONE;
                    i_resp_d  = 1'b1;
                    i_rdata_d = line_rdata;
                end
            end
            D_READ: begin
                if (line_done) begin
                    state_d   = DONE;
                    d_resp_d  = 1'b1;
                    d_rdata_d = line_rdata;
                end
            end
            D_WRITE: begin
                if (line_done) begin
                    state_d  = DONE;
                    d_resp_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= GRANT_I;
            i_resp_q  <= 1'b0;
            d_resp_q  <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            i_resp_q  <= i_resp_d;
            d_resp_q  <= d_resp_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    cacheline_adaptor #(
        .BEAT_WIDTH (BEAT_WIDTH),
        .BEATS      (BEATS),
        .LINE_WIDTH (LINE_WIDTH)
    ) u_adaptor (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .line_read     (start & ~start_write),
        .line_write    (start_write),
        .line_address  (start_addr),
        .line_wdata    (d_pmem_wdata),
        .line_rdata    (line_rdata),
        .line_done     (line_done),
        .burst_read    (burst_read),
        .burst_write   (burst_write),
        .burst_address (burst_address),
        .burst_wdata   (burst_wdata),
        .burst_rdata   (burst_rdata),
        .burst_resp    (burst_resp)
    );

    assign i_pmem_resp  = i_resp_q;
    assign d_pmem_resp  = d_resp_q;
    assign i_pmem_rdata = i_rdata_q;
    assign d_pmem_rdata = d_rdata_q;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Self-checking bench for l1_mem_arbiter: directed vector table, corner sequences, random traffic.
module tb_l1_mem_arbiter;

    localparam int BW = 64;
    localparam int NB = 4;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_pmem_read, d_pmem_read, d_pmem_write;
    logic [31:0]   i_pmem_address, d_pmem_address;
    logic [LW-1:0] i_pmem_rdata, d_pmem_rdata, d_pmem_wdata;
    logic          i_pmem_resp, d_pmem_resp;
    logic          burst_read, burst_write, burst_resp;
    logic [31:0]   burst_address;
    logic [BW-1:0] burst_wdata, burst_rdata;

    always #5 clk = ~clk;

    l1_mem_arbiter #(.BEAT_WIDTH(BW), .BEATS(NB), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .burst_read(burst_read), .burst_write(burst_write),
        .burst_address(burst_address), .burst_wdata(burst_wdata),
        .burst_rdata(burst_rdata), .burst_resp(burst_resp)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    function automatic logic [63:0] mem_word(input logic [31:0] a, input int k);
        return {a ^ 32'h5A5A_A5A5, 32'(k + 1) * 32'h1357_9BDF};
    endfunction

    function automatic logic [LW-1:0] mem_line(input logic [31:0] a);
        logic [LW-1:0] l;
        for (int k = 0; k < NB; k++) l[64*k +: 64] = mem_word(a, k);
        return l;
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a);
        return {a[31:5], 5'b0};
    endfunction

    logic          use_fixed = 1'b0;
    logic          rand_mem  = 1'b0;
    logic [BW-1:0] fixed_beats [NB];
    int            first_gap  = 0;
    int            stall_beat = -1;
    int            stall_len  = 0;
    logic [BW-1:0] wr_log [$];

    // Burst-side memory: answers beats with optional gaps, records write beats.
    initial begin
        int  mbeat = 0;
        int  gap = 0;
        logic in_burst = 1'b0;
        burst_resp  = 1'b0;
        burst_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst || !(burst_read || burst_write)) begin
                burst_resp = 1'b0;
                mbeat = 0;
                in_burst = 1'b0;
            end else begin
                if (!in_burst) begin
                    in_burst = 1'b1;
                    wr_log.delete();
                    gap = rand_mem ? int'($urandom_range(0, 2)) : first_gap;
                end else if (burst_resp) begin
                    mbeat++;
                    gap = rand_mem ? int'($urandom_range(0, 2)) : ((mbeat == stall_beat) ? stall_len : 0);
                end
                if (gap > 0) begin
                    gap--;
                    burst_resp = 1'b0;
                end else begin
                    burst_resp  = 1'b1;
                    burst_rdata = use_fixed ? fixed_beats[mbeat % NB] : mem_word(burst_address, mbeat);
                    if (burst_write) wr_log.push_back(burst_wdata);
                end
            end
        end
    end

    // ---------------- expected rdata holding registers ----------------
    logic [LW-1:0] m_i = '0;
    logic [LW-1:0] m_d = '0;

    typedef struct {
        logic          is_d;
        logic          rd;
        logic          wr;
        logic          fixed;
        logic [31:0]   addr;
        logic [LW-1:0] wdata;
        logic [31:0]   exp_addr;
        logic          exp_write;
        logic [LW-1:0] exp_line;
    } vec_t;

    task automatic do_reset();
        rst = 1'b1;
        i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0;
        i_pmem_address = '0; d_pmem_address = '0; d_pmem_wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_i = '0;
        m_d = '0;
    endtask

    task automatic wait_resp(input string name, output int cyc);
        cyc = 0;
        while (!(i_pmem_resp || d_pmem_resp) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, " resp timeout"}, (cyc < 200), 1'b1);
    endtask

    // One complete line transaction from an idle arbiter.
    task automatic do_txn(input vec_t v, input string name, input int exp_lat);
        int   cyc = 0;
        logic held_bad = 1'b0;
        use_fixed = v.fixed;
        @(negedge clk);
        if (v.is_d) begin
            d_pmem_read = v.rd; d_pmem_write = v.wr;
            d_pmem_address = v.addr; d_pmem_wdata = v.wdata;
        end else begin
            i_pmem_read = 1'b1; i_pmem_address = v.addr;
        end
        @(negedge clk);
        chk({name, " burst_read"}, burst_read, !v.exp_write);
        chk({name, " burst_write"}, burst_write, v.exp_write);
        chk({name, " burst_address"}, burst_address, v.exp_addr);
        while (!(i_pmem_resp || d_pmem_resp) && cyc < 200) begin
            if (!(burst_read || burst_write) || burst_address !== v.exp_addr) held_bad = 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk({name, " latency"}, cyc, exp_lat);
        chk({name, " strobe held"}, held_bad, 1'b0);
        chk({name, " i_resp"}, i_pmem_resp, !v.is_d);
        chk({name, " d_resp"}, d_pmem_resp, v.is_d);
        if (v.exp_write) begin
            chk({name, " beat count"}, wr_log.size(), NB);
            for (int k = 0; k < NB && k < wr_log.size(); k++)
                chk({name, " write beat"}, wr_log[k], v.wdata[64*k +: 64]);
        end else if (v.is_d) begin
            m_d = v.exp_line;
        end else begin
            m_i = v.exp_line;
        end
        chk({name, " i_rdata"}, i_pmem_rdata, m_i);
        chk({name, " d_rdata"}, d_pmem_rdata, m_d);
        i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0;
        @(negedge clk);
        chk({name, " resp one cycle"}, {i_pmem_resp, d_pmem_resp}, 2'b00);
    endtask

    localparam logic [LW-1:0] FIX_LINE =
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
    localparam logic [LW-1:0] DEAD_LINE =
        256'hDEAD0004_44444444_DEAD0003_33333333_DEAD0002_22222222_DEAD0001_1111BEEF;
    localparam logic [LW-1:0] MIX_LINE =
        256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;

    initial begin
        vec_t vecs [5];
        vec_t sv;
        int   c;
        vecs[0] = '{is_d:0, rd:1, wr:0, fixed:1, addr:32'h0000_1004, wdata:'0,
                    exp_addr:32'h0000_1000, exp_write:0, exp_line:FIX_LINE};
        vecs[1] = '{is_d:1, rd:0, wr:1, fixed:0, addr:32'h8000_0040, wdata:DEAD_LINE,
                    exp_addr:32'h8000_0040, exp_write:1, exp_line:'0};
        vecs[2] = '{is_d:1, rd:1, wr:1, fixed:0, addr:32'h0000_2000, wdata:MIX_LINE,
                    exp_addr:32'h0000_2000, exp_write:1, exp_line:'0};
        vecs[3] = '{is_d:1, rd:1, wr:0, fixed:0, addr:32'h8000_0047, wdata:'0,
                    exp_addr:32'h8000_0040, exp_write:0, exp_line:mem_line(32'h8000_0040)};
        vecs[4] = '{is_d:0, rd:1, wr:0, fixed:0, addr:32'hFFFF_FFFF, wdata:'0,
                    exp_addr:32'hFFFF_FFE0, exp_write:0, exp_line:mem_line(32'hFFFF_FFE0)};
        fixed_beats[0] = 64'h1111111111111111;
        fixed_beats[1] = 64'h2222222222222222;
        fixed_beats[2] = 64'h3333333333333333;
        fixed_beats[3] = 64'h4444444444444444;

        // reset state
        do_reset();
        chk("reset strobes", {burst_read, burst_write, i_pmem_resp, d_pmem_resp}, 4'b0);
        chk("reset address", burst_address, 32'h0);
        chk("reset wdata", burst_wdata, 64'h0);
        chk("reset i_rdata", i_pmem_rdata, '0);
        chk("reset d_rdata", d_pmem_rdata, '0);

        // directed vector table
        for (int n = 0; n < 5; n++) do_txn(vecs[n], $sformatf("vec%0d", n), 4);

        // 5-cycle memory stall between beats 1 and 2
        stall_beat = 2; stall_len = 5;
        sv = '{is_d:1, rd:1, wr:0, fixed:0, addr:32'h0000_6010, wdata:'0,
               exp_addr:32'h0000_6000, exp_write:0, exp_line:mem_line(32'h0000_6000)};
        do_txn(sv, "stall", 9);
        stall_beat = -1;

        // simultaneous I and D after reset: D first, then I right after DONE->IDLE
        do_reset();
        use_fixed = 0;
        @(negedge clk);
        i_pmem_read = 1; i_pmem_address = 32'h0000_3000;
        d_pmem_read = 1; d_pmem_address = 32'h0000_4020;
        @(negedge clk);
        chk("tie D first addr", burst_address, 32'h0000_4020);
        chk("tie D first read", burst_read, 1'b1);
        wait_resp("tie D", c);
        chk("tie D resp", {i_pmem_resp, d_pmem_resp}, 2'b01);
        m_d = mem_line(32'h0000_4020);
        chk("tie D rdata", d_pmem_rdata, m_d);
        d_pmem_read = 0;
        @(negedge clk);
        chk("tie idle gap", burst_read, 1'b0);
        @(negedge clk);
        chk("tie I next strobe", burst_read, 1'b1);
        chk("tie I next addr", burst_address, 32'h0000_3000);
        wait_resp("tie I", c);
        chk("tie I resp", {i_pmem_resp, d_pmem_resp}, 2'b10);
        m_i = mem_line(32'h0000_3000);
        chk("tie I rdata", i_pmem_rdata, m_i);
        i_pmem_read = 0;
        @(negedge clk);

        // reset in the middle of a D read after two beats
        stall_beat = 2; stall_len = 8;
        @(negedge clk);
        d_pmem_read = 1; d_pmem_address = 32'h0000_5000;
        repeat (3) @(negedge clk);
        chk("midreset in burst", burst_read, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset strobe drop", {burst_read, burst_write}, 2'b00);
        chk("midreset no resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
        rst = 1'b0; d_pmem_read = 0; m_i = '0; m_d = '0;
        stall_beat = -1;
        @(negedge clk);
        chk("midreset still no resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
        sv = '{is_d:0, rd:1, wr:0, fixed:0, addr:32'h0000_1000, wdata:'0,
               exp_addr:32'h0000_1000, exp_write:0, exp_line:mem_line(32'h0000_1000)};
        do_txn(sv, "after reset", 4);

        // random traffic against a transaction-level model
        begin
            logic          ip = 0, dp = 0, dw = 0, prev_strobe = 0, snap_i = 0, snap_d = 0;
            logic          act = 0, act_d = 0, last_d = 0, exp_d, drop_i, drop_d;
            logic [31:0]   ia = '0, da = '0;
            logic [LW-1:0] dwd = '0;
            int            cyc = 0;
            int            sel;
            do_reset();
            rand_mem = 1'b1;
            while (cyc < 3000 || ip || dp) begin
                @(negedge clk);
                cyc++;
                if (cyc > 3600) begin
                    chk("random drain", 1'b0, 1'b1);
                    break;
                end
                if ((burst_read || burst_write) && !prev_strobe) begin
                    exp_d = (snap_i && snap_d) ? !last_d : snap_d;
                    chk("rnd grant had request", snap_i | snap_d, 1'b1);
                    chk("rnd grant address", burst_address, align(exp_d ? da : ia));
                    chk("rnd grant write", burst_write, exp_d && dw);
                    last_d = exp_d; act = 1; act_d = exp_d;
                end
                prev_strobe = burst_read || burst_write;
                drop_i = 0; drop_d = 0;
                if (i_pmem_resp || d_pmem_resp) begin
                    chk("rnd resp while active", act, 1'b1);
                    chk("rnd resp side", {i_pmem_resp, d_pmem_resp}, act_d ? 2'b01 : 2'b10);
                    if (act_d && dw) begin
                        chk("rnd write beats", wr_log.size(), NB);
                        for (int k = 0; k < NB && k < wr_log.size(); k++)
                            chk("rnd write beat", wr_log[k], dwd[64*k +: 64]);
                    end else if (act_d) begin
                        m_d = mem_line(align(da));
                    end else begin
                        m_i = mem_line(align(ia));
                    end
                    chk("rnd i_rdata", i_pmem_rdata, m_i);
                    chk("rnd d_rdata", d_pmem_rdata, m_d);
                    if (act_d) begin
                        dp = 0; d_pmem_read = 0; d_pmem_write = 0; drop_d = 1;
                    end else begin
                        ip = 0; i_pmem_read = 0; drop_i = 1;
                    end
                    act = 0;
                end
                if (cyc < 3000) begin
                    if (!ip && !drop_i && $urandom_range(0, 3) == 0) begin
                        ip = 1; ia = $urandom;
                        i_pmem_read = 1; i_pmem_address = ia;
                    end
                    if (!dp && !drop_d && $urandom_range(0, 3) == 0) begin
                        dp = 1; da = $urandom; sel = int'($urandom_range(0, 2));
                        for (int j = 0; j < 8; j++) dwd[32*j +: 32] = $urandom;
                        d_pmem_read = (sel != 1); d_pmem_write = (sel != 0);
                        dw = (sel != 0);
                        d_pmem_address = da; d_pmem_wdata = dwd;
                    end
                end
                snap_i = ip; snap_d = dp;
            end
            rand_mem = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
